// File: rtl/mdu_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
// Op codes, FSM states and the divider iteration count.
package mdu_pkg;
    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    localparam int DIV_ITER = 32;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} mdu_state_t;
endpackage

// File: rtl/div_core.sv
// Iterative restoring divider on operand magnitudes, one quotient bit per cycle.
// Latency: W cycles after start; valid marks the last iteration, results are final the cycle after.
// Backpressure: none; start while running is not expected, flush aborts immediately.
module div_core
    import mdu_pkg::*;
#(
    parameter int W = DIV_ITER
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         flush,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    input  logic         neg_q,
    input  logic         neg_r,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         valid
);
    localparam int CW = $clog2(W);

    logic [W-1:0]  rem_q, quo_q, dvs_q;
    logic [CW-1:0] cnt;
    logic          run, nq, nr;
    logic [W:0]    shifted, trial;

    // rem < divisor always holds, so the W+1-bit trial MSB is a clean borrow flag.
    assign shifted = {rem_q, quo_q[W-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt   <= '0;
            run   <= 1'b0;
            nq    <= 1'b0;
            nr    <= 1'b0;
        end else if (flush) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt   <= '0;
            run   <= 1'b1;
            nq    <= neg_q;
            nr    <= neg_r;
        end else if (run) begin
            rem_q <= trial[W] ? shifted[W-1:0] : trial[W-1:0];
            quo_q <= {quo_q[W-2:0], ~trial[W]};
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(W - 1))
                run <= 1'b0;
        end
    end

    assign valid     = run && (cnt == CW'(W - 1));
    assign quotient  = nq ? -quo_q : quo_q;
    assign remainder = nr ? -rem_q : rem_q;
endmodule

// File: rtl/mul_div_unit.sv
// Execute-stage MULT/DIV unit owning the architectural HI/LO registers.
// Latency: MULT/MULTU 1 cycle, DIV/DIVU 33 cycles, MTHI/MTLO written at the accepting edge.
// Backpressure: busy holds the front of the pipeline; start while busy is dropped, flush aborts.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int DIV_BITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    mdu_state_t  state, state_nx;
    logic        accept, mul_go, div_go;
    logic [31:0] a_q, b_q;
    logic        mul_signed;
    logic [63:0] a_ext, b_ext, product;

    logic        div_signed, a_neg, b_neg, div_neg_q, div_valid;
    logic [31:0] a_mag, b_mag, div_quo, div_rem;

    always_ff @(posedge clk) begin
        if (rst || flush)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (mul_go)
                    state_nx = MUL;
                else if (div_go)
                    state_nx = DIV;
            end
            MUL:     state_nx = IDLE;
            DIV:     if (div_valid) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        accept = (state == IDLE) && start && !flush;
        mul_go = accept && (op == MDU_MULT || op == MDU_MULTU);
        div_go = accept && (op == MDU_DIV || op == MDU_DIVU);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            mul_signed <= 1'b0;
        end else if (mul_go) begin
            a_q        <= rs_val;
            b_q        <= rt_val;
            mul_signed <= (op == MDU_MULT);
        end
    end

    // Sign-extending to 64 bits lets one unsigned multiplier serve both MULT and MULTU.
    assign a_ext   = {{32{mul_signed & a_q[31]}}, a_q};
    assign b_ext   = {{32{mul_signed & b_q[31]}}, b_q};
    assign product = a_ext * b_ext;

    assign div_signed = (op == MDU_DIV);
    assign a_neg      = div_signed & rs_val[31];
    assign b_neg      = div_signed & rt_val[31];
    assign a_mag      = a_neg ? -rs_val : rs_val;
    assign b_mag      = b_neg ? -rt_val : rt_val;
    // On divide-by-zero the raw quotient is all ones and the remainder fix-up restores rs_val,
    // so suppressing only the quotient negation yields LO=all ones, HI=rs_val.
    assign div_neg_q  = (a_neg ^ b_neg) && (rt_val != '0);

    div_core #(.W(DIV_BITS)) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (div_go),
        .flush     (flush),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .neg_q     (div_neg_q),
        .neg_r     (a_neg),
        .quotient  (div_quo),
        .remainder (div_rem),
        .valid     (div_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!flush) begin
                case (state)
                    IDLE: begin
                        if (start && op == MDU_MTHI) hi <= rs_val;
                        if (start && op == MDU_MTLO) lo <= rs_val;
                    end
                    MUL: begin
                        {hi, lo} <= product;
                        done     <= 1'b1;
                    end
                    FIX: begin
                        lo   <= div_quo;
                        hi   <= div_rem;
                        done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
